// File: rtl/counter.sv
// Up-counter with enable and terminal value MAX_COUNT; wraps by default, saturates when COUNTER_SATURATE_EN is defined.
// Latency: one cycle from a sampled enable to the new value on out; reset clears out asynchronously.
// Backpressure: none; enable is the only flow control, and out is driven straight from the count flop.
module counter #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_nxt;
    logic             at_max;

    // The increment is truncated to WIDTH bits before the terminal compare.
    assign count_inc = count + WIDTH'(1);
    assign at_max    = (count == MAX_COUNT);

    always_comb begin
        count_nxt = count_inc;
        if (at_max) begin
`ifdef COUNTER_SATURATE_EN
            count_nxt = MAX_COUNT;
`else
            count_nxt = '0;
`endif
        end
    end

    // An X or Z on enable makes the condition false, so the count holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (enable == 1'b1) begin
            count <= count_nxt;
        end
    end

    assign out = count;

endmodule

// File: tb/tb_counter.sv
// Directed test of counter: async reset, enable gating, wrap or saturate, hold, reset mid-count.
module tb_counter;

`ifdef COUNTER_SATURATE_EN
    localparam logic [3:0] MAXC = 4'd12;
`else
    localparam logic [3:0] MAXC = 4'd15;
`endif

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] out;

    int total = 0;
    int bad   = 0;

    counter #(.WIDTH(4), .MAX_COUNT(MAXC)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .out    (out)
    );

    // Rising edges at t=10,20,...; t=5 falls between edges.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        #5;
        reset = 1'b0;
        #1;
        total++;
        if (out !== 4'd0) begin
            bad++;
            $display("FAIL reset_async: out=%0d want=0 t=%0t", out, $time);
        end
        // Reset must win over enable.
        enable = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out !== 4'd0) begin
            bad++;
            $display("FAIL reset_vs_enable: out=%0d want=0", out);
        end
        #3;
        total++;
        if (out !== 4'd0) begin
            bad++;
            $display("FAIL reset_held: out=%0d want=0", out);
        end
        enable = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_enable_gating();
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out !== 4'd0) begin
                bad++;
                $display("FAIL gate_low[%0d]: out=%0d want=0", i, out);
            end
        end
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out !== 4'(i)) begin
                bad++;
                $display("FAIL gate_count[%0d]: out=%0d want=%0d", i, out, i);
            end
        end
        enable = 1'b0;
    endtask

`ifndef COUNTER_SATURATE_EN
    task automatic test_wrap();
        logic [3:0] exp_tab [1:17];
        for (int i = 1; i <= 15; i++) exp_tab[i] = 4'(i);
        exp_tab[16] = 4'd0;
        exp_tab[17] = 4'd1;
        pulse_reset();
        enable = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out !== exp_tab[i]) begin
                bad++;
                $display("FAIL wrap[%0d]: out=%0d want=%0d", i, out, exp_tab[i]);
            end
        end
        enable = 1'b0;
    endtask
`else
    task automatic test_saturate();
        logic [3:0] exp_v;
        pulse_reset();
        enable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            exp_v = (i < 12) ? 4'(i) : 4'd12;
            @(posedge clk);
            #1;
            total++;
            if (out !== exp_v) begin
                bad++;
                $display("FAIL saturate[%0d]: out=%0d want=%0d", i, out, exp_v);
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (out !== 4'd0) begin
            bad++;
            $display("FAIL saturate_reset: out=%0d want=0", out);
        end
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask
`endif

    task automatic test_hold();
        pulse_reset();
        enable = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        total++;
        if (out !== 4'd7) begin
            bad++;
            $display("FAIL hold_reach7: out=%0d want=7", out);
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // A brief high pulse between edges must not count.
            #2 enable = 1'b1;
            #2 enable = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (out !== 4'd7) begin
                bad++;
                $display("FAIL hold[%0d]: out=%0d want=7", i, out);
            end
        end
        enable = 1'bx;
        @(posedge clk);
        #1;
        total++;
        if (out !== 4'd7) begin
            bad++;
            $display("FAIL enable_x: out=%0d want=7", out);
        end
        enable = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out !== 4'd8) begin
            bad++;
            $display("FAIL hold_resume: out=%0d want=8", out);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        pulse_reset();
        enable = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        total++;
        if (out !== 4'd9) begin
            bad++;
            $display("FAIL mid_reach9: out=%0d want=9", out);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (out !== 4'd0) begin
            bad++;
            $display("FAIL mid_async: out=%0d want=0", out);
        end
        @(posedge clk);
        #1;
        total++;
        if (out !== 4'd0) begin
            bad++;
            $display("FAIL mid_held: out=%0d want=0", out);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out !== 4'd1) begin
            bad++;
            $display("FAIL mid_resume: out=%0d want=1", out);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_enable_gating();
`ifndef COUNTER_SATURATE_EN
        test_wrap();
`else
        test_saturate();
`endif
        test_hold();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter.md
# counter

Parameterizable synchronous binary up-counter with count enable and asynchronous active-low reset. Used as a general-purpose event/cycle counter wherever a small free-running or gated count is needed; its output drives downstream logic directly from flops.

## Interface
- WIDTH, 4, counter width in bits; legal range 1–32.
- MAX_COUNT, 2**WIDTH-1, terminal value. Must be ≤ 2**WIDTH-1 and ≥ 1.
- clk  input  1  rising-edge clock; all state changes on this edge except reset.
- reset  input  1  asynchronous, active-low reset; low clears the counter immediately.
- enable  input  1  count enable, sampled on rising clk; high = advance one step.
- out  output  WIDTH  current count value, registered.

Port order is fixed: clk, reset, enable, out.

## Operation
- The single state register is the count value, and `out` is driven directly from that register. There is no combinational path from any input to `out`.
- reset low: count forced to 0 immediately, independent of clk. Count held at 0 while reset is low.
- reset high, enable high, rising clk edge:
  - if count < MAX_COUNT: count ← count + 1;
  - if count == MAX_COUNT: count ← 0 (wrap), or count holds at MAX_COUNT (see Configuration).
- reset high, enable low, rising clk edge: count holds its value.
- Arithmetic is unsigned, modulo 2**WIDTH. The increment result is truncated to WIDTH bits before the MAX_COUNT compare is applied.
- An X/Z level on enable must not corrupt the count in simulation. Treat any non-1 level as low.

## Timing
- Latency: enable sampled high at edge N gives the new value on `out` immediately after edge N (one register stage).
- Reset assertion is asynchronous: `out` = 0 within the same time step that reset falls, with no clk edge required.
- Reset deassertion is seen synchronously. The first possible increment is the first rising clk edge after reset goes high, provided enable is high at that edge.
- Reset mid-count: the count is lost and `out` = 0. Counting resumes from 0 after release.
- Reset low and enable high together: reset wins and `out` stays 0.
- Enable toggling between edges has no effect. Only the level at the rising edge matters.
- Power-up value before the first reset is undefined. The system must assert reset before use.

## Configuration
- Macro: COUNTER_SATURATE_EN.
- Not defined (default): at count == MAX_COUNT with enable high, the next edge wraps the count to 0, giving a modulo-(MAX_COUNT+1) counter.
- Defined: at count == MAX_COUNT with enable high, the count holds at MAX_COUNT. Only reset returns it to 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset: clk period 10, reset low at t=5, held for 10 → `out` = 0 at t=5, mid-cycle, with no edge needed. The value stays 0 for the whole reset pulse.
- Enable gating: reset high, enable low for 2 edges → `out` stays 0. Then enable high for 10 edges → `out` = 1, 2, …, 10, one step per edge.
- Wrap (default build, WIDTH=4): enable high for 16 edges after reset → `out` runs 1…15 then returns to 0 on the 16th edge. The 17th edge gives 1.
- Hold: count at 7, enable low for 5 edges → `out` stays 7. Enable high again → 8 on the next edge.
- Reset mid-count: count at 9 with enable high, reset pulled low between edges → `out` = 0 immediately. After release with enable high, the first edge gives 1.
- Saturate build (COUNTER_SATURATE_EN, MAX_COUNT=12): enable high for 20 edges after reset → `out` reaches 12 on edge 12 and stays 12. Reset gives 0.
